// File: rtl/if_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_unit
// Brief    : Instruction-fetch program counter. Forms the branch target from
//            the pre-shifted word offset, selects the next PC from sequential,
//            branch and jump sources under stall, drives the IF/ID flush and
//            keeps a one-deep redirect buffer so a redirect resolved while the
//            pipe is stalled is applied once the stall releases.
//            Optional macro PC_PERF_CNT_EN adds a saturating 32-bit
//            redirect_count output.
// Revision : 1.0 - initial release
// ============================================================================
module if_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_base,
    input  logic [WIDTH-1:0] branch_offset_sl2,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             redirect_pending
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]      redirect_count
`endif
);

    localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(4);

    logic [WIDTH-1:0] r_pc;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_pend_target;

    logic [WIDTH-1:0] w_branch_target;
    logic             w_live_req;
    logic [WIDTH-1:0] w_live_target;

    // Redirect source decode: jump wins over a simultaneous taken branch.
    always_comb begin
        w_branch_target = branch_base + branch_offset_sl2;
        w_live_req      = jump | branch_taken;
        w_live_target   = jump ? jump_target : w_branch_target;
    end

    // PC register and one-deep redirect buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (stall) begin
            // PC frozen; remember the newest redirect seen during the stall.
            if (w_live_req) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_live_target;
            end
        end else if (w_live_req) begin
            // A live request supersedes anything buffered.
            r_pc         <= w_live_target;
            r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
        end else begin
            r_pc <= pc_plus4;
        end
    end

    // Output drive: flush marks the cycle a redirect is taken, never under stall or reset.
    always_comb begin
        pc               = r_pc;
        pc_plus4         = r_pc + c_pc_step;
        redirect_pending = r_pend_valid;
        flush            = rst_n & ~stall & (w_live_req | r_pend_valid);
    end

`ifdef PC_PERF_CNT_EN
    logic [31:0] r_redirect_count;

    // Saturating count of applied redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect_count <= '0;
        end else if (flush && (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign redirect_count = r_redirect_count;
`endif

endmodule
`default_nettype wire
